display_capture: RTL and testbench
==================================

Name: display_capture

Overview:
- Receive side of the LED-matrix scan interface: samples the row/column drive lines produced by the display block and rebuilds the full gs x gs frame bitmap.
- Used as a loopback checker in the game top and for verifying the display path.
- Uses the same enable/done handshake as the other game blocks (e_*/d_*).

Parameters:
- gs, 8: grid size; the frame is gs x gs.
- stable, 2: consecutive identical cycles a row pattern must be held before it is captured (>=1).
- timeout, 1024: maximum cycles in SCAN before aborting (>=gs*stable).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- e_cap_i  input  1  enable/start capture (level).
- row_i  input  gs  row drive; one-hot, active-high; bit r selects row r.
- col_i  input  gs  column drive for the active row; bit c = 1 means pixel (r,c) is lit.
- matrix_o  output  gs*gs  last completed frame; bit r*gs+c = pixel (r,c).
- frame_valid_o  output  1  one-cycle pulse when matrix_o is updated.
- d_cap_o  output  1  done; held high in DONE until e_cap_i falls.
- err_o  output  1  sticky error: malformed row pattern or timeout.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; matrix_o, buffer, seen mask, stable counter, timeout counter, previous-row register, frame_valid_o, d_cap_o and err_o all 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On e_cap_i=1: clear buffer, seen mask, stable counter, timeout counter and previous-row register.
  - Clear err_o.
  - Go to SCAN next cycle.
- SCAN, every cycle:
  - Timeout counter increments.
  - prev_row <= row_i.
  - row_i == 0 (blanking): stable counter <= 0; no write.
  - row_i has more than one bit set: err_o <= 1; stable counter <= 0; no write.
  - row_i one-hot and equal to prev_row: stable counter increments, saturating at stable.
  - row_i one-hot and not equal to prev_row: stable counter <= 1.
  - When the stable counter reaches exactly stable on this cycle (one write per hold): buffer row r <= col_i and seen[r] <= 1. A row seen again later in the same frame overwrites; latest value wins.
  - With stable=1, every one-hot row that differs from the previous cycle captures immediately.
- Frame complete:
  - Condition: the seen mask including this cycle's write is all ones.
  - matrix_o <= buffer with this cycle's write merged in.
  - frame_valid_o = 1 for exactly that cycle.
  - Go to DONE. Latency from the completing row sample edge to matrix_o update is 1 cycle.
- Timeout: the timeout counter reaches timeout without the frame completing.
  - err_o <= 1.
  - matrix_o unchanged; no frame_valid_o.
  - Go to DONE.
- Completion and timeout on the same cycle: completion wins; err_o is not set by the timeout.
- e_cap_i falls during SCAN: abort to IDLE. matrix_o and err_o are unchanged, no pulse, d_cap_o stays 0.
- DONE:
  - d_cap_o=1 while in DONE.
  - When e_cap_i=0: d_cap_o <= 0 and go to IDLE.
  - With e_cap_i held high, the block stays in DONE; no re-arm without a low phase.
- err_o remains set until the next IDLE->SCAN start or reset.
- Reset asserted mid-SCAN: immediate return to reset values; the partial frame is lost.

Optional Feature:
- Macro: DISPLAY_CAPTURE_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt_o, 8 bits: saturating count (stops at 255) of malformed-row cycles plus timeouts.
  - Cleared only by reset, not by a new capture.
  - A cycle that is both malformed and the timeout cycle counts 2, saturating.
- Undefined: port and counter are absent; err_o behaviour is identical in both builds.

Test Plan:
- Clean frame: reset, e_cap_i=1, drive rows 0..7 each for 3 cycles with 1 blanking cycle between, col = 8'h01<<r -> one frame_valid_o pulse 1 cycle after the row 7 capture; matrix_o holds a diagonal (bits 0,9,18,...,63); d_cap_o=1; err_o=0.
- Glitch rejection (stable=2): row_i=8'h04 for 1 cycle with col=8'hFF, then blanking -> row 2 is not captured; seen[2] stays 0 and no pulse occurs before row 2 is later held 2 cycles.
- Malformed row: row_i=8'h18 for 1 cycle during SCAN -> err_o=1 next cycle and no write; the frame still completes if all rows are later captured; err_o remains 1 in DONE.
- Timeout: drive only rows 0..6 repeatedly -> after timeout cycles d_cap_o=1, err_o=1, no frame_valid_o, matrix_o equals the previous frame.
- Handshake: hold e_cap_i high after DONE for 10 cycles -> no new capture and d_cap_o stays 1. Drop e_cap_i -> d_cap_o=0 next cycle. Raise it again -> new SCAN with err_o cleared.
- Async reset mid-SCAN after 4 rows: assert rst_i between clock edges -> all outputs 0 immediately. With DISPLAY_CAPTURE_ERR_CNT_EN, 300 malformed cycles -> err_cnt_o=255.

Source files
------------

// File: rtl/display_capture.sv
// LED-matrix scan receiver: debounces one-hot row strobes and rebuilds the gs x gs frame.
// Optional build macro DISPLAY_CAPTURE_ERR_CNT_EN adds the saturating err_cnt_o counter.
`timescale 1ns/1ps
module display_capture #(
   parameter int gs      = 8,
   parameter int stable  = 2,
   parameter int timeout = 1024
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               e_cap_i,
   input  logic [gs-1:0]      row_i,
   input  logic [gs-1:0]      col_i,
   output logic [gs*gs-1:0]   matrix_o,
   output logic               frame_valid_o,
   output logic               d_cap_o,
   output logic               err_o
`ifdef DISPLAY_CAPTURE_ERR_CNT_EN
   ,output logic [7:0]        err_cnt_o
`endif
);

   localparam int SW = $clog2(stable + 1);
   localparam int TW = $clog2(timeout + 1);
   localparam logic [SW-1:0] c_stab_max = SW'(stable);
   localparam logic [TW-1:0] c_tmax     = TW'(timeout);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t            r_state;
   logic [gs*gs-1:0]  r_buf;
   logic [gs*gs-1:0]  r_matrix;
   logic [gs-1:0]     r_seen;
   logic [gs-1:0]     r_prev;
   logic [SW-1:0]     r_stab;
   logic [TW-1:0]     r_tcnt;
   logic              r_fv;
   logic              r_done;
   logic              r_err;

   logic              w_onehot;
   logic              w_malformed;
   logic              w_same;
   logic              w_wr;
   logic              w_complete;
   logic              w_tout;
   logic [SW-1:0]     w_stab_nxt;
   logic [TW-1:0]     w_tcnt_nxt;
   logic [gs-1:0]     w_seen_nxt;
   logic [gs*gs-1:0]  w_buf_nxt;

   assign w_onehot    = (row_i != '0) && ((row_i & (row_i - gs'(1))) == '0);
   assign w_malformed = (row_i != '0) && !w_onehot;
   assign w_same      = (row_i == r_prev);
   assign w_tcnt_nxt  = r_tcnt + TW'(1);
   assign w_tout      = (w_tcnt_nxt == c_tmax);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_stab_nxt = '0;
      if (w_onehot) begin
         if (!w_same)                     w_stab_nxt = SW'(1);
         else if (r_stab == c_stab_max)   w_stab_nxt = r_stab;
         else                             w_stab_nxt = r_stab + SW'(1);
      end
      // One write per hold: the counter must arrive at stable, not sit there.
      w_wr = w_onehot && (w_stab_nxt == c_stab_max) && !(w_same && (r_stab == c_stab_max));
      w_buf_nxt = r_buf;
      for (int r = 0; r < gs; r++) begin
         if (w_wr && row_i[r]) w_buf_nxt[r*gs +: gs] = col_i;
      end
      w_seen_nxt = w_wr ? (r_seen | row_i) : r_seen;
      w_complete = &w_seen_nxt;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_buf    <= '0;
         r_matrix <= '0;
         r_seen   <= '0;
         r_prev   <= '0;
         r_stab   <= '0;
         r_tcnt   <= '0;
         r_fv     <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_fv <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (e_cap_i) begin
                  r_buf   <= '0;
                  r_seen  <= '0;
                  r_stab  <= '0;
                  r_tcnt  <= '0;
                  r_prev  <= '0;
                  r_err   <= 1'b0;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (!e_cap_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_tcnt <= w_tcnt_nxt;
                  r_prev <= row_i;
                  r_stab <= w_stab_nxt;
                  r_buf  <= w_buf_nxt;
                  r_seen <= w_seen_nxt;
                  if (w_malformed) r_err <= 1'b1;
                  if (w_complete) begin
                     r_matrix <= w_buf_nxt;
                     r_fv     <= 1'b1;
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end else if (w_tout) begin
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (!e_cap_i) begin
                  r_done  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign matrix_o      = r_matrix;
   assign frame_valid_o = r_fv;
   assign d_cap_o       = r_done;
   assign err_o         = r_err;

`ifdef DISPLAY_CAPTURE_ERR_CNT_EN
   logic [7:0] r_err_cnt;
   logic [1:0] w_err_inc;
   logic [8:0] w_err_sum;

   // A malformed timeout cycle contributes two events; a completing cycle never counts a timeout.
   assign w_err_inc = (r_state == S_SCAN && e_cap_i)
                    ? ({1'b0, w_malformed} + {1'b0, w_tout && !w_complete}) : 2'd0;
   assign w_err_sum = {1'b0, r_err_cnt} + {7'd0, w_err_inc};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_err_cnt <= '0;
      else       r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
   end

   assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_display_capture.sv
// Scoreboard bench for display_capture: stimulus queues expected frames, a monitor checks each pulse.
// Also exercises err_cnt_o when built with DISPLAY_CAPTURE_ERR_CNT_EN.
`timescale 1ns/1ps
module tb_display_capture;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        e_cap_i;
   logic [7:0]  row_i;
   logic [7:0]  col_i;
   logic [63:0] matrix_o;
   logic        frame_valid_o;
   logic        d_cap_o;
   logic        err_o;
`ifdef DISPLAY_CAPTURE_ERR_CNT_EN
   logic [7:0]  err_cnt_o;
`endif

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_exp;

   localparam logic [63:0] c_diag   = 64'h8040_2010_0804_0201;
   localparam logic [63:0] c_frame2 = 64'h1716_1514_1312_1110;

   always #5 clk_i = ~clk_i;

   display_capture #(.gs(8), .stable(2), .timeout(1024)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .e_cap_i       (e_cap_i),
      .row_i         (row_i),
      .col_i         (col_i),
      .matrix_o      (matrix_o),
      .frame_valid_o (frame_valid_o),
      .d_cap_o       (d_cap_o),
      .err_o         (err_o)
`ifdef DISPLAY_CAPTURE_ERR_CNT_EN
      ,.err_cnt_o    (err_cnt_o)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic hold_row(input int r, input logic [7:0] col, input int n);
      row_i = 8'h01 << r;
      col_i = col;
      repeat (n) tick();
      row_i = 8'h00;
      tick();
   endtask

   // Monitor: every frame_valid_o pulse must match the oldest queued frame.
   always @(negedge clk_i) begin
      if (!rst_i && frame_valid_o) begin
         if (exp_q.size() == 0) begin
            check("frame_valid_unexpected", {63'd0, frame_valid_o}, 64'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("frame_matrix", matrix_o, mon_exp);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_i = 1'b1; e_cap_i = 1'b0; row_i = 8'h00; col_i = 8'h00;
      #12;
      check("rst_matrix", matrix_o, 64'd0);
      check("rst_fv",     {63'd0, frame_valid_o}, 64'd0);
      check("rst_done",   {63'd0, d_cap_o}, 64'd0);
      check("rst_err",    {63'd0, err_o}, 64'd0);
      @(negedge clk_i); rst_i = 1'b0;
      tick();

      // Clean diagonal frame, rows held 3 cycles with blanking between.
      e_cap_i = 1'b1; tick();
      exp_q.push_back(c_diag);
      for (int r = 0; r < 8; r++) hold_row(r, 8'h01 << r, 3);
      check("clean_done", {63'd0, d_cap_o}, 64'd1);
      check("clean_err",  {63'd0, err_o}, 64'd0);
      check("clean_drained", 64'(exp_q.size()), 64'd0);

      e_cap_i = 1'b0; tick();
      check("drop_done", {63'd0, d_cap_o}, 64'd0);
      e_cap_i = 1'b1; tick();

      // Glitch on row 2, then a malformed two-hot row.
      row_i = 8'h04; col_i = 8'hFF; tick();
      row_i = 8'h00; tick();
      row_i = 8'h18; col_i = 8'hEE; tick();
      check("malformed_err", {63'd0, err_o}, 64'd1);
      row_i = 8'h00; tick();
      for (int r = 0; r < 8; r++) if (r != 2) hold_row(r, 8'h10 + 8'(r), 2);
      check("glitch_not_captured", {63'd0, d_cap_o}, 64'd0);
      exp_q.push_back(c_frame2);
      hold_row(2, 8'h12, 2);
      check("frame2_done", {63'd0, d_cap_o}, 64'd1);
      check("frame2_err_sticky", {63'd0, err_o}, 64'd1);
      check("frame2_drained", 64'(exp_q.size()), 64'd0);

      // Enable held high in DONE: no re-arm.
      for (int i = 0; i < 10; i++) begin
         row_i = 8'h01 << (i % 8); col_i = 8'hF0; tick();
         check("done_hold", {63'd0, d_cap_o}, 64'd1);
      end
      e_cap_i = 1'b0; row_i = 8'h00; tick();
      check("handshake_drop", {63'd0, d_cap_o}, 64'd0);
      e_cap_i = 1'b1; tick();
      check("restart_err_clear", {63'd0, err_o}, 64'd0);

      // Timeout: only rows 0..6 ever appear.
      n = 0;
      while (d_cap_o == 1'b0 && n < 1200) begin
         row_i = ((n % 4) < 3) ? (8'h01 << ((n / 4) % 7)) : 8'h00;
         col_i = 8'h55;
         tick();
         n++;
      end
      check("timeout_cycles", 64'(n), 64'd1024);
      check("timeout_done",   {63'd0, d_cap_o}, 64'd1);
      check("timeout_err",    {63'd0, err_o}, 64'd1);
      check("timeout_matrix", matrix_o, c_frame2);
      check("timeout_no_fv",  {63'd0, frame_valid_o}, 64'd0);
      e_cap_i = 1'b0; row_i = 8'h00; tick();
      check("timeout_release", {63'd0, d_cap_o}, 64'd0);

      // Asynchronous reset between edges after 4 captured rows.
      e_cap_i = 1'b1; tick();
      for (int r = 0; r < 4; r++) hold_row(r, 8'hFF, 2);
      #2 rst_i = 1'b1;
      #1;
      check("async_rst_matrix", matrix_o, 64'd0);
      check("async_rst_fv",     {63'd0, frame_valid_o}, 64'd0);
      check("async_rst_done",   {63'd0, d_cap_o}, 64'd0);
      check("async_rst_err",    {63'd0, err_o}, 64'd0);
      e_cap_i = 1'b0; row_i = 8'h00;
      @(negedge clk_i); rst_i = 1'b0;
      tick();

`ifdef DISPLAY_CAPTURE_ERR_CNT_EN
      check("errcnt_rst", {56'd0, err_cnt_o}, 64'd0);
      e_cap_i = 1'b1; tick();
      row_i = 8'h18;
      repeat (300) tick();
      check("errcnt_sat", {56'd0, err_cnt_o}, 64'd255);
      check("errcnt_err", {63'd0, err_o}, 64'd1);
      e_cap_i = 1'b0; row_i = 8'h00; tick();
`endif

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
